// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the configurable UART transmitter:
//   - parity mode encodings (PAR_NONE / PAR_ODD / PAR_EVEN)
//   - transmitter FSM state type
//   - helpers deriving the baud divider and its counter width
// No ports (package).
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } tx_state_t;

  // Clock cycles per bit (integer division).
  function automatic int baud_cnt_max(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

  // Counter width; a divider of 1 would give a zero-width counter, so clamp to 1.
  function automatic int baud_cnt_width(input int cnt_max);
    return (cnt_max < 2) ? 1 : $clog2(cnt_max);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
// Generic synchronous show-ahead FIFO (pop_data is valid whenever !empty).
// Push while full is honoured only together with a pop; pop while empty is
// ignored.
// Parameters: WIDTH (word width), DEPTH (entries, power of two >= 2).
// Ports:
//   clk        in   clock
//   rst        in   synchronous reset, active high
//   push       in   write push_data
//   push_data  in   WIDTH
//   pop        in   discard head entry
//   pop_data   out  WIDTH, head entry
//   full       out  DEPTH entries stored
//   empty      out  no entries stored
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is fine.
  assign do_push  = push && (!full || pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// ----------------------------------------------------------------------------
// uart_tx_cfg
// Configurable RS232 transmitter: DATA_BITS data bits (LSB first), optional
// odd/even parity, 1 or 2 stop bits. Words are accepted on pi_flag && pi_ready
// and buffered so frames can run back to back without an idle cycle.
// Build option: define UART_TX_FIFO_EN to replace the one-entry holding
// register with a FIFO_DEPTH-entry FIFO.
// Ports:
//   sys_clk    in   system clock
//   sys_rst_n  in   synchronous reset, active HIGH (1 = reset)
//   pi_data    in   DATA_BITS, word to send
//   pi_flag    in   word valid
//   pi_ready   out  a word can be accepted this cycle
//   tx         out  serial line (registered, idle high)
//   tx_busy    out  FSM not idle or a word is buffered
//
// FSM states (tx lags the state by one cycle because it is registered):
//   state | meaning
//   IDLE  | line high, waiting for a buffered word
//   START | start bit (0), one bit time
//   DATA  | DATA_BITS data bits, LSB first
//   PAR   | parity bit, only when PARITY != PAR_NONE
//   STOP  | STOP_BITS stop bits (1); chains straight into START if a word waits
// ----------------------------------------------------------------------------
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int UART_BPS   = 9600,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [DATA_BITS-1:0] pi_data,
  input  logic                 pi_flag,
  output logic                 pi_ready,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam int CW           = baud_cnt_width(BAUD_CNT_MAX);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CNT_MAX - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || BAUD_CNT_MAX < 1 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_tx_cfg: illegal parameter combination");
  end

  tx_state_t            state;
  tx_state_t            state_nxt;
  logic [CW-1:0]        baud_cnt;
  logic                 baud_end;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 tx_nxt;

  logic                 accept;
  logic                 load;
  logic                 buf_valid;
  logic [DATA_BITS-1:0] buf_data;

  assign accept = pi_flag && pi_ready;

`ifdef UART_TX_FIFO_EN
  logic fifo_full;
  logic fifo_empty;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (sys_clk),
    .rst       (sys_rst_n),
    .push      (accept),
    .push_data (pi_data),
    .pop       (load),
    .pop_data  (buf_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pi_ready  = ~fifo_full;
  assign buf_valid = ~fifo_empty;
`else
  logic                 hold_valid;
  logic [DATA_BITS-1:0] hold_data;

  // accept needs an empty register and load needs a full one, so they never
  // coincide; the expression still refills correctly if they did.
  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else begin
      hold_valid <= accept || (hold_valid && !load);
      if (accept) hold_data <= pi_data;
    end
  end

  assign pi_ready  = ~hold_valid;
  assign buf_valid = hold_valid;
  assign buf_data  = hold_data;
`endif

  assign baud_end = (baud_cnt == BAUD_LAST);
  assign tx_busy  = (state != IDLE) || buf_valid;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    tx_nxt    = 1'b1;
    case (state)
      IDLE: begin
        if (buf_valid) begin
          state_nxt = START;
          load      = 1'b1;
        end
      end
      START: begin
        tx_nxt = 1'b0;
        if (baud_end) state_nxt = DATA;
      end
      DATA: begin
        tx_nxt = shreg[0];
        if (baud_end && bit_idx == DATA_LAST)
          state_nxt = (PARITY != PAR_NONE) ? PAR : STOP;
      end
      PAR: begin
        tx_nxt = par_bit;
        if (baud_end) state_nxt = STOP;
      end
      STOP: begin
        tx_nxt = 1'b1;
        if (baud_end && bit_idx == STOP_LAST) begin
          if (buf_valid) begin
            state_nxt = START;
            load      = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state <= state_nxt;
      tx    <= tx_nxt;

      if (state == IDLE || baud_end) baud_cnt <= '0;
      else                           baud_cnt <= baud_cnt + 1'b1;

      // bit_idx counts bits within DATA and STOP, restarting on every state change.
      if (state_nxt != state) bit_idx <= '0;
      else if (baud_end)      bit_idx <= bit_idx + 1'b1;

      if (load) begin
        shreg   <= buf_data;
        par_bit <= (PARITY == PAR_EVEN) ? ^buf_data : ~^buf_data;
      end else if (state == DATA && baud_end) begin
        shreg <= {1'b0, shreg[DATA_BITS-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_cfg
// Four transmitter instances at 10 clocks per bit:
//   d0 = 8N1, d1 = 8E1, d2 = 8O1, d3 = 7N2 (d0 also used for back-to-back,
//   reset and, when UART_TX_FIFO_EN is defined, FIFO-depth-4 sequences).
// Frames are written with bit i = i-th bit on the line (start bit is bit 0).
// ----------------------------------------------------------------------------
module tb_uart_tx_cfg;

  localparam int BIT_CYC = 10;

  logic       clk;
  logic [3:0] rst;
  logic [3:0] flag;
  logic [8:0] din;

  logic tx0, tx1, tx2, tx3;
  logic rdy0, rdy1, rdy2, rdy3;
  logic bsy0, bsy1, bsy2, bsy3;
  logic [3:0] tx_v, ready_v, busy_v;

  assign tx_v    = {tx3, tx2, tx1, tx0};
  assign ready_v = {rdy3, rdy2, rdy1, rdy0};
  assign busy_v  = {bsy3, bsy2, bsy1, bsy0};

  int n_checks;
  int n_fail;

  uart_tx_cfg #(.UART_BPS(5_000_000), .CLK_FREQ(50_000_000), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_d0 (
    .sys_clk(clk), .sys_rst_n(rst[0]), .pi_data(din[7:0]), .pi_flag(flag[0]),
    .pi_ready(rdy0), .tx(tx0), .tx_busy(bsy0));

  uart_tx_cfg #(.UART_BPS(5_000_000), .CLK_FREQ(50_000_000), .DATA_BITS(8),
                .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_d1 (
    .sys_clk(clk), .sys_rst_n(rst[1]), .pi_data(din[7:0]), .pi_flag(flag[1]),
    .pi_ready(rdy1), .tx(tx1), .tx_busy(bsy1));

  uart_tx_cfg #(.UART_BPS(5_000_000), .CLK_FREQ(50_000_000), .DATA_BITS(8),
                .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_d2 (
    .sys_clk(clk), .sys_rst_n(rst[2]), .pi_data(din[7:0]), .pi_flag(flag[2]),
    .pi_ready(rdy2), .tx(tx2), .tx_busy(bsy2));

  uart_tx_cfg #(.UART_BPS(5_000_000), .CLK_FREQ(50_000_000), .DATA_BITS(7),
                .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_d3 (
    .sys_clk(clk), .sys_rst_n(rst[3]), .pi_data(din[6:0]), .pi_flag(flag[3]),
    .pi_ready(rdy3), .tx(tx3), .tx_busy(bsy3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  typedef struct {
    int         dut;
    logic [8:0] data;
    logic [11:0] frame;
    int         nbits;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present one word for one cycle; returns #1 after the accepting edge.
  task automatic send(input int d, input logic [8:0] w);
    din     = w;
    flag[d] = 1'b1;
    @(posedge clk); #1;
    flag[d] = 1'b0;
  endtask

  // Samples every cycle of every bit; busy must stay high except in the final
  // stop bit, where the FSM may already be back in IDLE.
  task automatic check_frame(input int d, input logic [11:0] f, input int n, input string name);
    logic act;
    logic busy_act;
    busy_act = 1'b1;
    for (int b = 0; b < n; b++) begin
      act = f[b];
      for (int c = 0; c < BIT_CYC; c++) begin
        @(posedge clk); #1;
        if (tx_v[d] !== f[b]) act = tx_v[d];
        if (b < n - 1 && busy_v[d] !== 1'b1) busy_act = busy_v[d];
      end
      chk($sformatf("%s bit%0d", name, b), 32'(act), 32'(f[b]));
    end
    chk($sformatf("%s busy", name), 32'(busy_act), 32'd1);
  endtask

  task automatic check_quiet(input int d, input int cycles, input string name);
    logic tx_act;
    logic busy_act;
    tx_act   = 1'b1;
    busy_act = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (tx_v[d] !== 1'b1) tx_act = tx_v[d];
      if (busy_v[d] !== 1'b0) busy_act = busy_v[d];
    end
    chk($sformatf("%s tx idle", name), 32'(tx_act), 32'd1);
    chk($sformatf("%s busy idle", name), 32'(busy_act), 32'd0);
  endtask

  function automatic logic [11:0] frame8n1(input logic [7:0] w);
    return {3'b001, w, 1'b0};
  endfunction

  initial begin
    logic [7:0] fw [6];
    n_checks = 0;
    n_fail   = 0;
    rst  = 4'hF;
    flag = 4'h0;
    din  = '0;

    //          dut data    frame (bit0 = start)     bits
    vecs[0] = '{0, 9'h55, 12'b0010_1010_1010, 10};  // 8N1 0x55
    vecs[1] = '{1, 9'hA5, 12'b0101_0100_1010, 11};  // 8E1 0xA5, parity 0
    vecs[2] = '{2, 9'hA5, 12'b0111_0100_1010, 11};  // 8O1 0xA5, parity 1
    vecs[3] = '{3, 9'h41, 12'b0011_1000_0010, 10};  // 7N2 0x41
    vecs[4] = '{0, 9'h00, 12'b0010_0000_0000, 10};  // 8N1 0x00
    vecs[5] = '{1, 9'h01, 12'b0110_0000_0010, 11};  // 8E1 0x01, parity 1
    vecs[6] = '{3, 9'h7F, 12'b0011_1111_1110, 10};  // 7N2 0x7F
    vecs[7] = '{2, 9'hFF, 12'b0111_1111_1110, 11};  // 8O1 0xFF, parity 1

    repeat (3) @(posedge clk); #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("reset tx d%0d", d),    32'(tx_v[d]),    32'd1);
      chk($sformatf("reset ready d%0d", d), 32'(ready_v[d]), 32'd1);
      chk($sformatf("reset busy d%0d", d),  32'(busy_v[d]),  32'd0);
    end
    rst = 4'h0;
    repeat (2) @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      int d;
      d = vecs[i].dut;
      send(d, vecs[i].data);
      chk($sformatf("v%0d tx after accept", i), 32'(tx_v[d]), 32'd1);
      chk($sformatf("v%0d busy after accept", i), 32'(busy_v[d]), 32'd1);
      @(posedge clk); #1;
      chk($sformatf("v%0d tx one edge later", i), 32'(tx_v[d]), 32'd1);
      check_frame(d, vecs[i].frame, vecs[i].nbits, $sformatf("v%0d", i));
      chk($sformatf("v%0d busy end", i), 32'(busy_v[d]), 32'd0);
      chk($sformatf("v%0d ready end", i), 32'(ready_v[d]), 32'd1);
      repeat (3) @(posedge clk); #1;
    end

    // Back-to-back frames on d0, plus a word offered while not ready.
    send(0, 9'h0F);
    fork
      begin
        @(posedge clk); #1;
        chk("b2b latency", 32'(tx_v[0]), 32'd1);
        check_frame(0, 12'b0010_0001_1110, 10, "b2b f1");
        check_frame(0, 12'b0011_1110_0000, 10, "b2b f2");
      end
      begin
        repeat (2) @(posedge clk); #1;
        chk("b2b ready during f1", 32'(ready_v[0]), 32'd1);
        din = 9'hF0; flag[0] = 1'b1;
        @(posedge clk); #1;
        flag[0] = 1'b0;
`ifndef UART_TX_FIFO_EN
        repeat (10) @(posedge clk); #1;
        chk("b2b ready full", 32'(ready_v[0]), 32'd0);
        din = 9'hAA; flag[0] = 1'b1;
        @(posedge clk); #1;
        flag[0] = 1'b0;
`endif
      end
    join
    chk("b2b ready end", 32'(ready_v[0]), 32'd1);
    check_quiet(0, 150, "b2b no third frame");

    // Reset 35 cycles into a 0x00 frame with a second word buffered.
    send(0, 9'h00);
    repeat (4) @(posedge clk); #1;
    din = 9'hFF; flag[0] = 1'b1;
    @(posedge clk); #1;
    flag[0] = 1'b0;
    repeat (31) @(posedge clk); #1;
    chk("rst mid-frame tx low", 32'(tx_v[0]), 32'd0);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    chk("rst tx", 32'(tx_v[0]), 32'd1);
    chk("rst busy", 32'(busy_v[0]), 32'd0);
    chk("rst ready", 32'(ready_v[0]), 32'd1);
    rst[0] = 1'b0;
    check_quiet(0, 150, "rst no resume");

`ifdef UART_TX_FIFO_EN
    // Six words back to back into a depth-4 FIFO: five frames, sixth dropped.
    fw = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    din = {1'b0, fw[0]}; flag[0] = 1'b1;
    chk("fifo ready w0", 32'(ready_v[0]), 32'd1);
    @(posedge clk); #1;
    fork
      begin
        for (int i = 1; i < 6; i++) begin
          din = {1'b0, fw[i]};
          chk($sformatf("fifo ready w%0d", i), 32'(ready_v[0]), (i < 5) ? 32'd1 : 32'd0);
          @(posedge clk); #1;
        end
        flag[0] = 1'b0;
      end
      begin
        @(posedge clk); #1;
        chk("fifo latency", 32'(tx_v[0]), 32'd1);
        for (int k = 0; k < 5; k++)
          check_frame(0, frame8n1(fw[k]), 10, $sformatf("fifo f%0d", k));
      end
    join
    check_quiet(0, 150, "fifo no sixth frame");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
